// File: rtl/regfile_debug_dumper.sv
// rtl/regfile_debug_dumper.sv - walks the register file debug port and streams every word out MSB byte first
module regfile_debug_dumper #(
    parameter int REGS    = 5,
    parameter int NB      = 32,
    parameter int TAM     = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [REGS-1:0]    o_reg_dir,
    input  logic [NB-1:0]      i_reg_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int NBYTES = NB / NB_BYTE;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [REGS-1:0]  LAST_REG  = REGS'(TAM - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t           state;
    logic [NB-1:0]    shift;
    logic [CNT_W-1:0] byte_cnt;
    logic [REGS-1:0]  reg_dir;
    logic             busy;
    logic             done;

    // Valid is pure state decode; the byte is always the top of the captured word.
    assign o_tx_valid = (state == ST_SEND);
    assign o_tx_data  = shift[NB-1 -: NB_BYTE];
    assign o_reg_dir  = reg_dir;
    assign o_busy     = busy;
    assign o_done     = done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            shift    <= '0;
            byte_cnt <= '0;
            reg_dir  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state   <= ST_LATCH;
                        reg_dir <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    shift    <= i_reg_data;
                    byte_cnt <= '0;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    // Without a handshake everything holds so the offered byte stays stable.
                    if (i_tx_ready) begin
                        if (byte_cnt != LAST_BYTE) begin
                            shift    <= shift << NB_BYTE;
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end else if (reg_dir != LAST_REG) begin
                            reg_dir <= reg_dir + REGS'(1);
                            state   <= ST_LATCH;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
